tl_ul_reg_responder: RTL and testbench

- TileLink-UL slave-side responder: accepts channel-A requests, updates/reads a small local register bank, returns one channel-D response per request.
- Completes the A-channel field path (3-bit opcode/param forwarding) that the core-side fabric drives toward peripherals.
- Used as the terminating endpoint for eval-harness control/status registers.
- One response buffered, fully pipelined: back-to-back requests at 1 per cycle when `d_ready` is held high.

---
 rtl/tl_ul_reg_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_tl_ul_reg_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL register-bank endpoint: one-deep D-channel response buffer,
// single-cycle response latency, full throughput while d_ready stays high.
module tl_ul_reg_responder #(
  parameter int NREGS    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int SOURCE_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [DATA_W-1:0]   d_data
);

  localparam int              IDX_W      = $clog2(NREGS);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NREGS * 4);

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  // Byte lanes a PutFull of this size at this lane offset must enable.
  function automatic logic [3:0] size_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << lane;
      3'd1:    m = 4'b0011 << {lane[1], 1'b0};
      3'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = lane[0];
      3'd2:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];

  logic                d_valid_q,   d_valid_d;
  logic [2:0]          d_opcode_q,  d_opcode_d;
  logic [2:0]          d_size_q,    d_size_d;
  logic [SOURCE_W-1:0] d_source_q,  d_source_d;
  logic                d_denied_q,  d_denied_d;
  logic                d_corrupt_q, d_corrupt_d;
  logic [DATA_W-1:0]   d_data_q,    d_data_d;

  logic [IDX_W-1:0]    idx_s;
  logic [1:0]          lane_s;
  logic                err_s;
  logic                full_mask_ok_s;
  logic                a_fire_s;
  logic                d_fire_s;
  logic                wr_en_s;
  logic [2:0]          rsp_opcode_s;
  logic                rsp_denied_s;
  logic                rsp_corrupt_s;
  logic [DATA_W-1:0]   rsp_data_s;

  assign a_ready  = !d_valid_q || d_ready;
  assign a_fire_s = a_valid && a_ready;
  assign d_fire_s = d_valid_q && d_ready;

  // Address/size/param decode shared by every opcode.
  always_comb begin
    idx_s          = a_address[IDX_W+1:2];
    lane_s         = a_address[1:0];
    err_s          = ({1'b0, a_address} >= ADDR_LIMIT) || (a_size > 3'd2) ||
                     misaligned(a_size, lane_s) || (a_param != 3'd0);
    full_mask_ok_s = (a_mask == size_mask(a_size, lane_s));
  end

  // Response contents and write enable for the request on the A channel.
  always_comb begin
    rsp_opcode_s  = D_ACCESS_ACK;
    rsp_denied_s  = 1'b0;
    rsp_corrupt_s = 1'b0;
    rsp_data_s    = '0;
    wr_en_s       = 1'b0;
    case (a_opcode)
      A_GET: begin
        rsp_opcode_s = D_ACCESS_ACK_DATA;
        if (err_s) begin
          rsp_denied_s  = 1'b1;
          rsp_corrupt_s = 1'b1;
        end else begin
          rsp_data_s = regs_q[idx_s];
        end
      end
      A_PUT_FULL: begin
        if (err_s || !full_mask_ok_s) begin
          rsp_denied_s = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end
      A_PUT_PARTIAL: begin
        if (err_s) begin
          rsp_denied_s = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end
      A_ARITHMETIC, A_LOGICAL: begin
        rsp_opcode_s  = D_ACCESS_ACK_DATA;
        rsp_denied_s  = 1'b1;
        rsp_corrupt_s = 1'b1;
      end
      A_INTENT: begin
        rsp_opcode_s = D_HINT_ACK;
      end
      default: begin
        rsp_denied_s = 1'b1;
      end
    endcase
  end

  // Byte-lane register update on an accepted, error-free Put.
  always_comb begin
    regs_d = regs_q;
    if (a_fire_s && wr_en_s) begin
      regs_d[idx_s] = merge_bytes(regs_q[idx_s], a_data, a_mask);
    end else begin
      regs_d = regs_q;
    end
  end

  // D buffer: reload on A-fire (even when draining), empty on a lone D-fire.
  always_comb begin
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;
    if (a_fire_s) begin
      d_valid_d   = 1'b1;
      d_opcode_d  = rsp_opcode_s;
      d_size_d    = a_size;
      d_source_d  = a_source;
      d_denied_d  = rsp_denied_s;
      d_corrupt_d = rsp_corrupt_s;
      d_data_d    = rsp_data_s;
    end else if (d_fire_s) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q      <= '{default: '0};
      d_valid_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
    end else begin
      regs_q      <= regs_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'b00;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_denied  = d_denied_q;
  assign d_corrupt = d_corrupt_q;
  assign d_data    = d_data_q;

endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Randomised + directed bench for tl_ul_reg_responder, checked every cycle
// against a transaction-level model of the register bank and response buffer.
module tb_tl_ul_reg_responder;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    rsp_t r;
    int   cyc;
  } log_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [2:0]  a_size = 3'd0;
  logic [1:0]  a_source = 2'd0;
  logic [5:0]  a_address = 6'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [1:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  log_t rsp_log[$];

  logic [31:0] mregs [4];
  logic        exp_valid = 1'b0;
  rsp_t        exp_rsp = '0;

  tl_ul_reg_responder dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t pack_dut();
    return rsp_t'{d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data};
  endfunction

  // Transaction-level model: decides the response and applies any write.
  function automatic rsp_t model_access(input logic [2:0] op, input logic [2:0] param,
                                        input logic [2:0] size, input logic [5:0] addr,
                                        input logic [3:0] mask, input logic [31:0] data,
                                        input logic [1:0] src);
    rsp_t r;
    int   a;
    int   nbytes;
    logic bad;
    logic exact;
    a = int'(addr);
    r = '0;
    r.size = size;
    r.source = src;
    bad = (a >= 16) || (size > 3'd2) || (param != 3'd0);
    nbytes = 1;
    if (!bad) begin
      nbytes = 1 << size;
      if ((a % nbytes) != 0) bad = 1'b1;
    end
    case (op)
      3'd4: begin
        r.opcode = 3'd1;
        if (bad) begin
          r.denied = 1'b1;
          r.corrupt = 1'b1;
        end else begin
          r.data = mregs[a / 4];
        end
      end
      3'd0, 3'd1: begin
        exact = 1'b1;
        if (op == 3'd0 && !bad) begin
          for (int l = 0; l < 4; l++) begin
            if (mask[l] != ((l >= a % 4) && (l < (a % 4) + nbytes))) exact = 1'b0;
          end
        end
        if (bad || !exact) begin
          r.denied = 1'b1;
        end else begin
          for (int l = 0; l < 4; l++) begin
            if (mask[l]) mregs[a / 4][8*l +: 8] = data[8*l +: 8];
          end
        end
      end
      3'd2, 3'd3: begin
        r.opcode = 3'd1;
        r.denied = 1'b1;
        r.corrupt = 1'b1;
      end
      3'd5: r.opcode = 3'd2;
      default: r.denied = 1'b1;
    endcase
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Per-cycle compare against the model, then advance the model one edge.
  initial begin
    logic a_f;
    logic d_f;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_d_fields", 64'(pack_dut()), 64'd0);
        exp_valid = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
      end else begin
        check("d_valid", 64'(d_valid), 64'(exp_valid));
        check("a_ready", 64'(a_ready), 64'(!exp_valid || d_ready));
        if (exp_valid) check("d_fields", 64'(pack_dut()), 64'(exp_rsp));
        if (d_valid && d_ready) rsp_log.push_back('{pack_dut(), cyc});
        a_f = a_valid && (!exp_valid || d_ready);
        d_f = exp_valid && d_ready;
        if (a_f) begin
          exp_rsp = model_access(a_opcode, a_param, a_size, a_address, a_mask, a_data, a_source);
          exp_valid = 1'b1;
        end else if (d_f) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                      input logic [5:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic [1:0] src);
    int   n;
    logic took;
    a_valid = 1'b1;
    a_opcode = op;
    a_param = param;
    a_size = size;
    a_address = addr;
    a_mask = mask;
    a_data = data;
    a_source = src;
    n = 0;
    took = 1'b0;
    while (!took && n < 64) begin
      @(negedge clock);
      took = a_ready;
      @(posedge clock);
      #1;
      if (rand_ready) d_ready = ($urandom_range(0, 2) != 0);
      n++;
    end
    if (!took) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: a_ready stayed 0 for %0d cycles, required 1", n);
    end
    a_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (rand_ready) d_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic check_log(input int i, input string name, input rsp_t exp);
    if (rsp_log.size() > i) begin
      check(name, 64'(rsp_log[i].r), 64'(exp));
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: response %0d missing, only %0d seen", name, i, rsp_log.size());
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [2:0]  pa;
    logic [5:0]  ad;
    logic [3:0]  mk;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset mid-response, then Get idx0 returns zero.
    d_ready = 1'b0;
    send(3'd0, 3'd0, 3'd2, 6'h00, 4'hF, 32'hCAFEF00D, 2'd0);
    check("t1_pending", 64'(d_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("t1_async_valid", 64'(d_valid), 64'd0);
    check("t1_async_fields", 64'(pack_dut()), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    d_ready = 1'b1;
    rsp_log.delete();
    send(3'd4, 3'd0, 3'd2, 6'h00, 4'hF, 32'd0, 2'd1);
    idle(2);
    check_log(0, "t1_get0", rsp_t'{3'd1, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 32'h0});

    // PutFull then Get.
    rsp_log.delete();
    send(3'd0, 3'd0, 3'd2, 6'h04, 4'hF, 32'hDEADBEEF, 2'd2);
    send(3'd4, 3'd0, 3'd2, 6'h04, 4'hF, 32'd0, 2'd0);
    idle(2);
    check_log(0, "t2_put_ack", rsp_t'{3'd0, 2'd0, 3'd2, 2'd2, 1'b0, 1'b0, 32'h0});
    check_log(1, "t2_get", rsp_t'{3'd1, 2'd0, 3'd2, 2'd0, 1'b0, 1'b0, 32'hDEADBEEF});

    // PutPartial lanes 0 and 2 over all-ones.
    rsp_log.delete();
    send(3'd0, 3'd0, 3'd2, 6'h08, 4'hF, 32'hFFFFFFFF, 2'd1);
    send(3'd1, 3'd0, 3'd2, 6'h08, 4'h5, 32'h11223344, 2'd1);
    send(3'd4, 3'd0, 3'd2, 6'h08, 4'hF, 32'd0, 2'd3);
    idle(2);
    check_log(1, "t3_partial_ack", rsp_t'{3'd0, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 32'h0});
    check_log(2, "t3_get", rsp_t'{3'd1, 2'd0, 3'd2, 2'd3, 1'b0, 1'b0, 32'hFF22FF44});

    // Backpressure: response held, A blocked, then simultaneous fire.
    rsp_log.delete();
    d_ready = 1'b0;
    send(3'd4, 3'd0, 3'd2, 6'h04, 4'hF, 32'd0, 2'd1);
    a_valid = 1'b1;
    a_opcode = 3'd4;
    a_param = 3'd0;
    a_size = 3'd2;
    a_address = 6'h08;
    a_mask = 4'hF;
    a_source = 2'd3;
    repeat (3) begin
      @(negedge clock);
      check("t4_a_blocked", 64'(a_ready), 64'd0);
      check("t4_hold_data", 64'(d_data), 64'hDEADBEEF);
    end
    @(posedge clock);
    #1 d_ready = 1'b1;
    @(negedge clock);
    check("t4_a_release", 64'(a_ready), 64'd1);
    @(posedge clock);
    #1 a_valid = 1'b0;
    idle(3);
    check("t4_count", 64'(rsp_log.size()), 64'd2);
    check_log(0, "t4_first", rsp_t'{3'd1, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 32'hDEADBEEF});
    check_log(1, "t4_second", rsp_t'{3'd1, 2'd0, 3'd2, 2'd3, 1'b0, 1'b0, 32'hFF22FF44});

    // Error cases leave registers untouched.
    rsp_log.delete();
    send(3'd4, 3'd0, 3'd2, 6'h10, 4'hF, 32'd0, 2'd0);
    send(3'd2, 3'd0, 3'd2, 6'h04, 4'hF, 32'h12345678, 2'd1);
    send(3'd0, 3'd0, 3'd2, 6'h0C, 4'h3, 32'hAAAAAAAA, 2'd2);
    send(3'd0, 3'd1, 3'd2, 6'h00, 4'hF, 32'h00005555, 2'd3);
    send(3'd4, 3'd0, 3'd2, 6'h04, 4'hF, 32'd0, 2'd0);
    send(3'd4, 3'd0, 3'd2, 6'h0C, 4'hF, 32'd0, 2'd1);
    send(3'd4, 3'd0, 3'd2, 6'h00, 4'hF, 32'd0, 2'd2);
    send(3'd5, 3'd0, 3'd2, 6'h00, 4'hF, 32'd0, 2'd3);
    send(3'd7, 3'd0, 3'd2, 6'h00, 4'hF, 32'd0, 2'd0);
    idle(2);
    check_log(0, "t5_get_range", rsp_t'{3'd1, 2'd0, 3'd2, 2'd0, 1'b1, 1'b1, 32'h0});
    check_log(1, "t5_arith", rsp_t'{3'd1, 2'd0, 3'd2, 2'd1, 1'b1, 1'b1, 32'h0});
    check_log(2, "t5_putfull_mask", rsp_t'{3'd0, 2'd0, 3'd2, 2'd2, 1'b1, 1'b0, 32'h0});
    check_log(3, "t5_param", rsp_t'{3'd0, 2'd0, 3'd2, 2'd3, 1'b1, 1'b0, 32'h0});
    check_log(4, "t5_reg1_kept", rsp_t'{3'd1, 2'd0, 3'd2, 2'd0, 1'b0, 1'b0, 32'hDEADBEEF});
    check_log(5, "t5_reg3_kept", rsp_t'{3'd1, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 32'h0});
    check_log(6, "t5_reg0_kept", rsp_t'{3'd1, 2'd0, 3'd2, 2'd2, 1'b0, 1'b0, 32'h0});
    check_log(7, "t5_intent", rsp_t'{3'd2, 2'd0, 3'd2, 2'd3, 1'b0, 1'b0, 32'h0});
    check_log(8, "t5_op7", rsp_t'{3'd0, 2'd0, 3'd2, 2'd0, 1'b1, 1'b0, 32'h0});

    // Streaming: alternating Put/Get, one response per cycle.
    rsp_log.delete();
    for (int i = 0; i < 8; i++) begin
      send((i % 2 == 0) ? 3'd0 : 3'd4, 3'd0, 3'd2, 6'((i / 2) * 4), 4'hF, $urandom, 2'(i % 4));
    end
    idle(2);
    check("t6_count", 64'(rsp_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < rsp_log.size()) begin
        check("t6_source", 64'(rsp_log[k].r.source), 64'(k % 4));
        check("t6_spacing", 64'(rsp_log[k].cyc - rsp_log[0].cyc), 64'(k));
      end
    end

    // Random traffic with random backpressure and gaps.
    rand_ready = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) op = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      ad = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((6'd1 << sz) - 6'd1);
      if ($urandom_range(0, 15) == 0) ad = 6'($urandom_range(16, 63));
      mk = 4'($urandom_range(0, 15));
      if (sz <= 3'd2 && $urandom_range(0, 2) != 0) mk = 4'(((1 << (1 << sz)) - 1) << ad[1:0]);
      pa = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      send(op, pa, sz, ad, mk, $urandom, 2'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    d_ready = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
